// File: rtl/textlcd_buf.sv
// HD44780-class 2-line character LCD controller (8-bit, write-only) with a 2 x COLS
// shadow buffer. It runs the power-up/init sequence, then streams the whole buffer on demand.
module textlcd_buf #(
   parameter int CLK_DIV       = 5,
   parameter int COLS          = 16,
   parameter int POWERUP_SLOTS = 70,
   parameter int CLEAR_SLOTS   = 200,
   parameter int AUTO_REFRESH  = 0,
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          wr_line,
   input  logic [CW-1:0] wr_col,
   input  logic [7:0]    wr_char,
   input  logic          refresh,
   output logic          busy,
   output logic          init_done,
   output logic          lcd_e,
   output logic          lcd_rs,
   output logic          lcd_rw,
   output logic [7:0]    lcd_data
);

   localparam int SLOT   = 2 * CLK_DIV;
   localparam int PW     = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int MAXA   = (POWERUP_SLOTS > CLEAR_SLOTS) ? POWERUP_SLOTS : CLEAR_SLOTS;
   localparam int MAXCNT = (MAXA > COLS) ? MAXA : COLS;
   localparam int SCW    = $clog2(MAXCNT + 1);

   typedef enum logic [3:0] {
      ST_POWERUP,
      ST_FUNC_SET,
      ST_DISP_ON,
      ST_ENTRY,
      ST_CLEAR,
      ST_CLEAR_WAIT,
      ST_IDLE,
      ST_ADDR1,
      ST_DATA1,
      ST_ADDR2,
      ST_DATA2
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [SCW-1:0]   slotCnt_q, slotCnt_d;
   logic             dirty_q, dirty_d;
   logic             pending_q, pending_d;
   logic             initDone_q, initDone_d;
   logic             lcdRs_q, rs_d;
   logic [7:0]       lcdData_q, data_d;
   logic [7:0]       charBuf_q [2][COLS];

   logic             slotEnd;
   logic             wrValid;
   logic             trigger;
   logic             enterAddr1;
   logic             strobeSlot;
   logic             lineSel;
   logic [CW-1:0]    colSel;
   logic [7:0]       nextChar;

   assign slotEnd = (phase_q == PW'(SLOT - 1));
   assign wrValid = wr_en && ({1'b0, wr_col} < (CW + 1)'(COLS));
   assign trigger = pending_q | refresh | dirty_q | (AUTO_REFRESH != 0);

   always_comb begin
      state_d    = state_q;
      slotCnt_d  = slotCnt_q;
      initDone_d = initDone_q;
      enterAddr1 = 1'b0;
      phase_d    = slotEnd ? '0 : phase_q + PW'(1);
      if (slotEnd) begin
         case (state_q)
            ST_POWERUP: begin
               if (slotCnt_q == SCW'(POWERUP_SLOTS - 1)) begin
                  state_d   = ST_FUNC_SET;
                  slotCnt_d = '0;
               end else begin
                  slotCnt_d = slotCnt_q + SCW'(1);
               end
            end
            ST_FUNC_SET: state_d = ST_DISP_ON;
            ST_DISP_ON:  state_d = ST_ENTRY;
            ST_ENTRY:    state_d = ST_CLEAR;
            ST_CLEAR: begin
               state_d   = ST_CLEAR_WAIT;
               slotCnt_d = '0;
            end
            ST_CLEAR_WAIT: begin
               if (slotCnt_q == SCW'(CLEAR_SLOTS - 1)) begin
                  state_d    = ST_IDLE;
                  slotCnt_d  = '0;
                  initDone_d = 1'b1;
               end else begin
                  slotCnt_d = slotCnt_q + SCW'(1);
               end
            end
            ST_IDLE: begin
               if (trigger) begin
                  state_d    = ST_ADDR1;
                  enterAddr1 = 1'b1;
               end
            end
            ST_ADDR1: begin
               state_d   = ST_DATA1;
               slotCnt_d = '0;
            end
            ST_DATA1: begin
               if (slotCnt_q == SCW'(COLS - 1)) begin
                  state_d   = ST_ADDR2;
                  slotCnt_d = '0;
               end else begin
                  slotCnt_d = slotCnt_q + SCW'(1);
               end
            end
            ST_ADDR2: begin
               state_d   = ST_DATA2;
               slotCnt_d = '0;
            end
            ST_DATA2: begin
               // Chain straight into the next refresh so continuous mode leaves no idle slot.
               if (slotCnt_q == SCW'(COLS - 1)) begin
                  slotCnt_d = '0;
                  if (trigger) begin
                     state_d    = ST_ADDR1;
                     enterAddr1 = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  slotCnt_d = slotCnt_q + SCW'(1);
               end
            end
            default: state_d = ST_POWERUP;
         endcase
      end
      dirty_d   = wrValid ? 1'b1 : (enterAddr1 ? 1'b0 : dirty_q);
      pending_d = enterAddr1 ? 1'b0 : (pending_q | refresh);
   end

   // Bus values for the slot about to start; a same-cycle write to the sampled cell is bypassed in.
   always_comb begin
      lineSel = (state_d == ST_DATA2);
      colSel  = slotCnt_d[CW-1:0];
      if (wrValid && (wr_line == lineSel) && (wr_col == colSel)) begin
         nextChar = wr_char;
      end else begin
         nextChar = charBuf_q[lineSel][colSel];
      end
      rs_d   = 1'b0;
      data_d = 8'h00;
      case (state_d)
         ST_FUNC_SET: data_d = 8'h38;
         ST_DISP_ON:  data_d = 8'h0C;
         ST_ENTRY:    data_d = 8'h06;
         ST_CLEAR:    data_d = 8'h01;
         ST_ADDR1:    data_d = 8'h80;
         ST_ADDR2:    data_d = 8'hC0;
         ST_DATA1, ST_DATA2: begin
            rs_d   = 1'b1;
            data_d = nextChar;
         end
         default: data_d = 8'h00;
      endcase
   end

   always_comb begin
      strobeSlot = 1'b0;
      case (state_q)
         ST_FUNC_SET, ST_DISP_ON, ST_ENTRY, ST_CLEAR,
         ST_ADDR1, ST_DATA1, ST_ADDR2, ST_DATA2: strobeSlot = 1'b1;
         default: strobeSlot = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_POWERUP;
         phase_q    <= '0;
         slotCnt_q  <= '0;
         dirty_q    <= 1'b0;
         pending_q  <= 1'b0;
         initDone_q <= 1'b0;
         lcdRs_q    <= 1'b0;
         lcdData_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         slotCnt_q  <= slotCnt_d;
         dirty_q    <= dirty_d;
         pending_q  <= pending_d;
         initDone_q <= initDone_d;
         if (slotEnd) begin
            lcdRs_q   <= rs_d;
            lcdData_q <= data_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < COLS; c++) begin
               charBuf_q[l][c] <= 8'h20;
            end
         end
      end else if (wrValid) begin
         charBuf_q[wr_line][wr_col] <= wr_char;
      end
   end

   assign lcd_e     = strobeSlot && (phase_q >= PW'(CLK_DIV));
   assign lcd_rs    = lcdRs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_data  = lcdData_q;
   assign init_done = initDone_q;
   assign busy      = (state_q != ST_IDLE) | pending_q | dirty_q | refresh;

endmodule
